// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 3-stage RISC-V pipeline (IF | DE/EX | MEM/WB).
// Contents:
//   hazard_state_t - state encoding of the hazard / memory-wait sequencer
//   NOP_INSTR      - canonical NOP (addi x0, x0, 0) loaded on flush/bubble
//   REG_X0         - architectural zero register address
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk1   - clock, rising edge
//   reset1 - asynchronous active-high reset, clears the count
//   inc    - count this cycle
//   cnt    - current count; sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk1,
    input  logic         reset1,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 3-stage RISC-V pipeline (IF | DE/EX | MEM/WB).
// Generates the global advance/freeze enables, branch flush and redirect,
// rs1/rs2 forwarding selects from MEM/WB, and runs the data-memory
// request/ready handshake with a bounded wait and a sticky error.
// Ports:
//   clk1, reset1        - clock (rising edge), async active-high reset
//   ex_rs1/ex_rs2       - source register addresses in DE/EX
//   ex_rs1_used/_rs2_.. - DE/EX instruction reads that source
//   ex_branch_taken     - DE/EX resolved a taken branch/jump
//   wb_rd, wb_reg_wr    - MEM/WB destination and write enable
//   wb_is_load/_store   - MEM/WB instruction accesses data memory
//   dmem_ready          - data memory completes the access this cycle
//   pc_en, pc_redirect  - PC update enable, load branch target
//   if_ex_en/_flush     - IF->DE/EX register enable / NOP load
//   ex_wb_en/_bubble    - DE/EX->MEM/WB register enable / NOP load
//   dmem_req            - data memory request
//   fwd_a, fwd_b        - select write-back data for rs1 / rs2
//   mem_err             - sticky memory timeout error
//   stall_cnt/flush_cnt - saturating performance counters
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk1,
    input  logic             reset1,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_rs1_used,
    input  logic             ex_rs2_used,
    input  logic             ex_branch_taken,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_wr,
    input  logic             wb_is_load,
    input  logic             wb_is_store,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_ex_en,
    output logic             if_ex_flush,
    output logic             ex_wb_en,
    output logic             ex_wb_bubble,
    output logic             dmem_req,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    hazard_state_t     state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              mem_op;
    logic              advance;
    logic              br_flush;
    logic              stall_inc;

    assign mem_op  = wb_is_load | wb_is_store;

    // A memory op with ready in the same cycle completes with zero wait.
    assign advance = ((state == RUN) && !(mem_op && !dmem_ready)) ||
                     ((state == MEM_WAIT) && dmem_ready);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                if (mem_op && !dmem_ready) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERROR;
                end else begin
                    wait_nxt = wait_cnt + WAIT_ONE;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state    <= INIT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Whole pipeline freezes together; a branch held in the frozen DE/EX
    // takes effect on the release cycle because it is gated by advance.
    assign br_flush     = ex_branch_taken && advance;

    assign pc_en        = advance;
    assign if_ex_en     = advance;
    assign ex_wb_en     = advance;
    assign pc_redirect  = br_flush;
    assign if_ex_flush  = (state == INIT) || br_flush;
    assign ex_wb_bubble = (state == INIT) || (state == ERROR);
    assign dmem_req     = mem_op && ((state == RUN) || (state == MEM_WAIT));
    assign mem_err      = (state == ERROR);

    // A load still waiting on memory has no valid data to forward; the
    // pipeline is frozen then, so dropping the select is harmless.
    // Held off in INIT so every output except the NOP loads reads 0.
    always_comb begin
        fwd_a = (state != INIT) && wb_reg_wr && (wb_rd != REG_X0) &&
                (wb_rd == ex_rs1) && ex_rs1_used && (!wb_is_load || dmem_ready);
        fwd_b = (state != INIT) && wb_reg_wr && (wb_rd != REG_X0) &&
                (wb_rd == ex_rs2) && ex_rs2_used && (!wb_is_load || dmem_ready);
    end

    assign stall_inc = !advance && (state != INIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk1   (clk1),
        .reset1 (reset1),
        .inc    (stall_inc),
        .cnt    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk1   (clk1),
        .reset1 (reset1),
        .inc    (br_flush),
        .cnt    (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one default instance and one small
// instance (MEM_TIMEOUT=4, CNT_W=2) driven by the same stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk1 = 1'b0;
    logic       reset1;
    logic [4:0] ex_rs1, ex_rs2, wb_rd;
    logic       ex_rs1_used, ex_rs2_used, ex_branch_taken;
    logic       wb_reg_wr, wb_is_load, wb_is_store, dmem_ready;

    logic        m_pc_en, m_pc_redirect, m_if_ex_en, m_if_ex_flush;
    logic        m_ex_wb_en, m_ex_wb_bubble, m_dmem_req, m_fwd_a, m_fwd_b, m_mem_err;
    logic [15:0] m_stall_cnt, m_flush_cnt;

    logic        s_pc_en, s_pc_redirect, s_if_ex_en, s_if_ex_flush;
    logic        s_ex_wb_en, s_ex_wb_bubble, s_dmem_req, s_fwd_a, s_fwd_b, s_mem_err;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk1 = ~clk1;

    pipeline_hazard_ctrl dut (
        .clk1(clk1), .reset1(reset1),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .ex_branch_taken(ex_branch_taken), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
        .wb_is_load(wb_is_load), .wb_is_store(wb_is_store), .dmem_ready(dmem_ready),
        .pc_en(m_pc_en), .pc_redirect(m_pc_redirect), .if_ex_en(m_if_ex_en),
        .if_ex_flush(m_if_ex_flush), .ex_wb_en(m_ex_wb_en), .ex_wb_bubble(m_ex_wb_bubble),
        .dmem_req(m_dmem_req), .fwd_a(m_fwd_a), .fwd_b(m_fwd_b), .mem_err(m_mem_err),
        .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_small (
        .clk1(clk1), .reset1(reset1),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .ex_branch_taken(ex_branch_taken), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
        .wb_is_load(wb_is_load), .wb_is_store(wb_is_store), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .pc_redirect(s_pc_redirect), .if_ex_en(s_if_ex_en),
        .if_ex_flush(s_if_ex_flush), .ex_wb_en(s_ex_wb_en), .ex_wb_bubble(s_ex_wb_bubble),
        .dmem_req(s_dmem_req), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        // inputs
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, br, wr, ld, st, rdy;
        // expected outputs (counters as seen before this cycle's edge)
        logic       pc, redir, flush, bub, req, fa, fb;
        int         sc, fc;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic [4:0] rs1, rs2, rd,
                                input logic u1, u2, br, wr, ld, st, rdy,
                                input logic pc, redir, flush, bub, req, fa, fb,
                                input int sc, fc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.br = br; v.wr = wr; v.ld = ld; v.st = st; v.rdy = rdy;
        v.pc = pc; v.redir = redir; v.flush = flush; v.bub = bub; v.req = req;
        v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        ex_rs1 = v.rs1; ex_rs2 = v.rs2; wb_rd = v.rd;
        ex_rs1_used = v.u1; ex_rs2_used = v.u2; ex_branch_taken = v.br;
        wb_reg_wr = v.wr; wb_is_load = v.ld; wb_is_store = v.st; dmem_ready = v.rdy;
    endtask

    initial begin
        //              rs1 rs2 rd  u1 u2 br wr ld st rdy   pc rd fl bb rq fa fb  sc fc
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 0, 0, 0, 0); // INIT
        tbl[1]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(5, 0, 5,  1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0); // load stalls
        tbl[4]  = mk(5, 0, 5,  1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[5]  = mk(5, 0, 5,  1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 0);
        tbl[6]  = mk(5, 0, 5,  1, 0, 0, 1, 1, 0, 1,  1, 0, 0, 0, 1, 1, 0, 3, 0); // ready
        tbl[7]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 3, 0);
        tbl[8]  = mk(5, 5, 5,  1, 0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0, 3, 0); // fwd rs1
        tbl[9]  = mk(0, 0, 0,  1, 0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 3, 0); // x0
        tbl[10] = mk(5, 5, 5,  0, 1, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 3, 0); // fwd rs2
        tbl[11] = mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 3, 0); // branch
        tbl[12] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 3, 1);
        tbl[13] = mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3, 1); // br+stall
        tbl[14] = mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 4, 1);
        tbl[15] = mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 1,  1, 1, 1, 0, 1, 0, 0, 5, 1); // release
        tbl[16] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 5, 2);
        tbl[17] = mk(0, 0, 0,  0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 0, 0, 5, 2); // 0-wait st
        tbl[18] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 5, 2);

        // reset state
        reset1 = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        chk("rst_pc_en", m_pc_en, 0);
        chk("rst_if_ex_flush", m_if_ex_flush, 1);
        chk("rst_ex_wb_bubble", m_ex_wb_bubble, 1);
        chk("rst_dmem_req", m_dmem_req, 0);
        chk("rst_mem_err", m_mem_err, 0);
        chk("rst_stall_cnt", m_stall_cnt, 0);
        chk("rst_flush_cnt", m_flush_cnt, 0);
        @(posedge clk1);
        #1 reset1 = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk1);
            chk($sformatf("r%0d_pc_en", i), m_pc_en, tbl[i].pc);
            chk($sformatf("r%0d_if_ex_en", i), m_if_ex_en, tbl[i].pc);
            chk($sformatf("r%0d_ex_wb_en", i), m_ex_wb_en, tbl[i].pc);
            chk($sformatf("r%0d_pc_redirect", i), m_pc_redirect, tbl[i].redir);
            chk($sformatf("r%0d_if_ex_flush", i), m_if_ex_flush, tbl[i].flush);
            chk($sformatf("r%0d_ex_wb_bubble", i), m_ex_wb_bubble, tbl[i].bub);
            chk($sformatf("r%0d_dmem_req", i), m_dmem_req, tbl[i].req);
            chk($sformatf("r%0d_fwd_a", i), m_fwd_a, tbl[i].fa);
            chk($sformatf("r%0d_fwd_b", i), m_fwd_b, tbl[i].fb);
            chk($sformatf("r%0d_mem_err", i), m_mem_err, 0);
            chk($sformatf("r%0d_stall_cnt", i), m_stall_cnt, tbl[i].sc);
            chk($sformatf("r%0d_flush_cnt", i), m_flush_cnt, tbl[i].fc);
            chk($sformatf("r%0d_small_stall_cnt", i), s_stall_cnt, (tbl[i].sc > 3) ? 3 : tbl[i].sc);
            chk($sformatf("r%0d_small_pc_en", i), s_pc_en, tbl[i].pc);
            @(posedge clk1);
            #1;
        end

        // Timeout on the small instance: 1 RUN stall cycle, 4 MEM_WAIT cycles,
        // then ERROR from k=5 on. The default instance is still waiting.
        ex_branch_taken = 1'b0; wb_reg_wr = 1'b0; wb_is_store = 1'b0;
        wb_is_load = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            chk($sformatf("to%0d_small_mem_err", k), s_mem_err, (k >= 5) ? 1 : 0);
            chk($sformatf("to%0d_small_dmem_req", k), s_dmem_req, (k >= 5) ? 0 : 1);
            chk($sformatf("to%0d_small_bubble", k), s_ex_wb_bubble, (k >= 5) ? 1 : 0);
            chk($sformatf("to%0d_small_flush", k), s_if_ex_flush, 0);
            chk($sformatf("to%0d_small_pc_en", k), s_pc_en, 0);
            chk($sformatf("to%0d_main_mem_err", k), m_mem_err, 0);
            chk($sformatf("to%0d_main_dmem_req", k), m_dmem_req, 1);
            @(posedge clk1);
            #1;
        end

        // Reset mid-wait aborts the request without waiting for an edge.
        reset1 = 1'b1;
        #1;
        chk("arst_main_dmem_req", m_dmem_req, 0);
        chk("arst_small_mem_err", s_mem_err, 0);
        chk("arst_main_stall_cnt", m_stall_cnt, 0);
        @(posedge clk1);
        #1 reset1 = 1'b0;
        wb_is_load = 1'b0; dmem_ready = 1'b1;
        @(negedge clk1);
        chk("post_rst_init_flush", s_if_ex_flush, 1);
        chk("post_rst_init_pc_en", s_pc_en, 0);
        @(negedge clk1);
        chk("post_rst_run_pc_en", s_pc_en, 1);
        chk("post_rst_run_mem_err", s_mem_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
